// File: rtl/act_scheduler.sv
// act_scheduler: time-multiplexed activation controller. A captured vector of
// N signed Q(QM.QN) pre-activations is streamed one element per cycle through
// a single external combinational sigmoid; the 8-bit results are collected
// into out_vec and presented with a valid/ready handshake.
// Optional build macro: ACT_SCHED_SAT_CNT_EN adds a sticky 16-bit counter of
// elements falling outside the sigmoid LUT's +/-4.0 input range.
module act_scheduler #(
    parameter int N  = 2,
    parameter int QM = 6,
    parameter int QN = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N*(QM+QN)-1:0]     in_vec,
    output logic [QM+QN-1:0]         sig_x,
    input  logic [7:0]               sig_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*N-1:0]           out_vec,
    output logic                     busy
`ifdef ACT_SCHED_SAT_CNT_EN
    ,
    output logic [15:0]              sat_cnt
`endif
);

    localparam int W  = QM + QN;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [W-1:0]    cap [N];

    // Shared sigmoid operand: current captured element while running, else zero
    assign sig_x = (state == RUN) ? cap[idx] : '0;

    // Control FSM with registered handshake flags, capture register and result collection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            out_vec   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            for (int unsigned k = 0; k < N; k++) cap[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int unsigned k = 0; k < N; k++) cap[k] <= in_vec[k*W +: W];
                        idx      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    out_vec[idx*8 +: 8] <= sig_y;
                    if (idx == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef ACT_SCHED_SAT_CNT_EN
    // Element scaled so that +/-4.0 maps to +/-128; beyond that the LUT clips
    logic signed [31:0] sx_scaled;
    logic               sat_hit;

    assign sx_scaled = 32'(signed'(sig_x)) >>> (QN - 5);
    assign sat_hit   = (state == RUN) && ((sx_scaled > 32'sd128) || (sx_scaled < -32'sd128));

    // Sticky saturation counter, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (sat_hit && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_act_scheduler.sv
// Self-checking bench for act_scheduler: directed tests pinned by literals,
// then randomized traffic checked every cycle against a timeline model.
module tb_act_scheduler;

    localparam int N  = 2;
    localparam int QM = 6;
    localparam int QN = 10;
    localparam int W  = QM + QN;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (N=2)
    logic             in_valid, in_ready, out_valid, out_ready, busy;
    logic [N*W-1:0]   in_vec;
    logic [W-1:0]     sig_x;
    logic [7:0]       sig_y;
    logic [8*N-1:0]   out_vec;

    // Second DUT (N=1)
    logic             in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [W-1:0]     in_vec1, sig_x1;
    logic [7:0]       sig_y1, out_vec1;

`ifdef ACT_SCHED_SAT_CNT_EN
    logic [15:0] sat_cnt, sat_cnt1;
`endif

    assign sig_y  = sig_x[7:0]  ^ 8'h5A;
    assign sig_y1 = sig_x1[7:0] ^ 8'h5A;

    act_scheduler #(.N(N), .QM(QM), .QN(QN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_vec(in_vec), .sig_x(sig_x), .sig_y(sig_y), .out_valid(out_valid),
        .out_ready(out_ready), .out_vec(out_vec), .busy(busy)
`ifdef ACT_SCHED_SAT_CNT_EN
        , .sat_cnt(sat_cnt)
`endif
    );

    act_scheduler #(.N(1), .QM(QM), .QN(QN)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_vec(in_vec1), .sig_x(sig_x1), .sig_y(sig_y1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_vec(out_vec1), .busy(busy1)
`ifdef ACT_SCHED_SAT_CNT_EN
        , .sat_cnt(sat_cnt1)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: t = -1 idle, 0..N-1 element t on the sigmoid, N = result presented
    int         t;
    int         elem [N];
    logic [7:0] old_res [N];
    int         sat_m;

    function automatic logic [7:0] stub(input int x);
        return 8'(x) ^ 8'h5A;
    endfunction

    function automatic bit is_sat(input int x);
        int s;
        s = x >>> (QN - 5);
        return (s > 128) || (s < -128);
    endfunction

    function automatic logic [8*N-1:0] exp_vec();
        logic [8*N-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++)
            r[k*8 +: 8] = (t >= 0 && k < t) ? stub(elem[k]) : old_res[k];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, %0t)", nm, act, exp, t, $time);
        end
    endtask

    task automatic model_reset();
        t = -1;
        sat_m = 0;
        for (int k = 0; k < N; k++) begin
            elem[k] = 0;
            old_res[k] = 8'h00;
        end
    endtask

    // Effect of one active clock edge with the currently driven inputs
    task automatic model_edge();
        if (t < 0) begin
            if (in_valid) begin
                for (int k = 0; k < N; k++) elem[k] = $signed(in_vec[k*W +: W]);
                t = 0;
            end
        end else if (t < N) begin
            if (is_sat(elem[t]) && sat_m < 65535) sat_m++;
            t++;
        end else if (out_ready) begin
            for (int k = 0; k < N; k++) old_res[k] = stub(elem[k]);
            t = -1;
        end
    endtask

    task automatic compare_all();
        logic [W-1:0] sx;
        sx = (t >= 0 && t < N) ? W'(elem[t]) : '0;
        chk("in_ready", 64'(in_ready), 64'(t < 0));
        chk("out_valid", 64'(out_valid), 64'(t == N));
        chk("busy", 64'(busy), 64'(t >= 0));
        chk("sig_x", 64'(sig_x), 64'(sx));
        chk("out_vec", 64'(out_vec), 64'(exp_vec()));
`ifdef ACT_SCHED_SAT_CNT_EN
        chk("sat_cnt", 64'(sat_cnt), 64'(sat_m));
`endif
    endtask

    // Called at a falling edge: drive, apply model edge, wait, compare
    task automatic tick(input logic iv, input logic [N*W-1:0] v, input logic ordy);
        in_valid  = iv;
        in_vec    = v;
        out_ready = ordy;
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [W-1:0] rand_elem();
        logic [W-1:0] e;
        int edges [9] = '{4095, 4096, 4127, 4128, 4129, -4096, -4097, -4128, -4129};
        case ($urandom % 4)
            0:       e = W'($urandom);
            1:       e = W'($signed($urandom_range(0, 600)) - 300);
            default: e = W'(edges[$urandom_range(0, 8)]);
        endcase
        return e;
    endfunction

    initial begin
        logic [N*W-1:0] v;
        in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
        in_valid1 = 1'b0; in_vec1 = '0; out_ready1 = 1'b1;
        model_reset();

        // Reset state
        @(negedge clk);
        compare_all();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sig_x", 64'(sig_x), 64'd0);
        chk("rst_out_vec", 64'(out_vec), 64'd0);
        rst_n = 1'b1;

        // Basic vector on N=2, single element on N=1
        in_valid1 = 1'b1; in_vec1 = 16'h00FF;
        tick(1'b1, 32'h0012_0034, 1'b1);
        chk("basic_sig_x0", 64'(sig_x), 64'h0034);
        chk("n1_busy", 64'(busy1), 64'd1);
        chk("n1_sig_x", 64'(sig_x1), 64'h00FF);
        in_valid1 = 1'b0;
        tick(1'b0, '0, 1'b1);
        chk("basic_sig_x1", 64'(sig_x), 64'h0012);
        chk("n1_out_valid", 64'(out_valid1), 64'd1);
        chk("n1_out_vec", 64'(out_vec1), 64'hA5);
        tick(1'b0, '0, 1'b0);
        chk("basic_out_valid", 64'(out_valid), 64'd1);
        chk("basic_out_vec", 64'(out_vec), 64'h486E);

        // Backpressure with in_valid asserted in DONE
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, {$urandom, $urandom}, 1'b0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_vec", 64'(out_vec), 64'h486E);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        tick(1'b0, '0, 1'b1);
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_stale_vec", 64'(out_vec), 64'h486E);

        // Reset one cycle after capture
        tick(1'b1, 32'h1111_2222, 1'b1);
        tick(1'b0, '0, 1'b1);
        do_reset();
        chk("midrst_out_vec", 64'(out_vec), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);

        // Saturation vector, twice
        for (int r = 1; r <= 2; r++) begin
            tick(1'b1, 32'h0400_4000, 1'b1);
            tick(1'b0, '0, 1'b1);
            tick(1'b0, '0, 1'b0);
            chk("sat_vec_out", 64'(out_vec), 64'h5A5A);
`ifdef ACT_SCHED_SAT_CNT_EN
            chk("sat_cnt_lit", 64'(sat_cnt), 64'(r));
`endif
            tick(1'b0, '0, 1'b1);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                for (int k = 0; k < N; k++) v[k*W +: W] = rand_elem();
                tick(1'($urandom % 2), v, 1'($urandom % 3 != 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
